// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// default geometry and stream framing constants.
package imem_pkg;

    localparam int WIDTH_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT  = 1024;
    localparam int DEPTH_MAX      = 65535;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_BITS      = 8 * BYTES_PER_WORD;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    // Busy covers every state in which the stream is being consumed or written.
    function automatic logic state_is_busy(input state_t s);
        return (s == S_HDR0) || (s == S_HDR1) || (s == S_DATA) || (s == S_WRITE);
    endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Collects little-endian stream bytes into one instruction word, one lane
// per load, lane selected by the byte index.
module imem_word_assembler
    import imem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load,
    input  logic [1:0]           idx,
    input  logic [7:0]           byte_in,
    output logic [WORD_BITS-1:0] word
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word <= '0;
        end else if (load) begin
            word[8*idx +: 8] <= byte_in;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: parses a 16-bit word count
// header, assembles little-endian words and emits one write strobe per word.
module imem_loader
    import imem_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             we,
    output logic [WIDTH-1:0] waddr,
    output logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam logic [16:0]      DEPTH_L  = 17'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    state_t           state;
    logic [15:0]      count;
    logic [15:0]      addr;
    logic [IDX_W-1:0] idx;

    logic                 xfer;
    logic [15:0]          hdr_n;
    logic [15:0]          addr_inc;
    logic                 asm_clear;
    logic                 asm_load;
    logic [WORD_BITS-1:0] asm_word;

    // The final byte of a word lands in the assembler on the same edge that
    // wdata is captured, so the top lane is merged in directly from byte_in.
    function automatic logic [WORD_BITS-1:0] merge_last_lane(
        input logic [WORD_BITS-1:0] partial,
        input logic [7:0]           b
    );
        logic [WORD_BITS-1:0] w;
        w = partial;
        w[WORD_BITS-1 -: 8] = b;
        return w;
    endfunction

    assign xfer      = byte_valid && byte_ready;
    assign hdr_n     = {byte_in, count[7:0]};
    assign addr_inc  = addr + 16'd1;
    assign asm_load  = xfer && (state == S_DATA);
    assign asm_clear = xfer && (state == S_HDR1);

    imem_word_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .clear   (asm_clear),
        .load    (asm_load),
        .idx     (idx),
        .byte_in (byte_in),
        .word    (asm_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            we         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            count      <= '0;
            idx        <= '0;
            addr       <= '0;
        end else begin
            we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_HDR0;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                    end
                end

                S_HDR0: begin
                    if (xfer) begin
                        count[7:0] <= byte_in;
                        state      <= S_HDR1;
                    end
                end

                S_HDR1: begin
                    if (xfer) begin
                        count[15:8] <= byte_in;
                        idx         <= '0;
                        addr        <= '0;
                        if (hdr_n == 16'd0) begin
                            state      <= S_DONE;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else if ({1'b0, hdr_n} > DEPTH_L) begin
                            state      <= S_ERR;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            error      <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state      <= S_WRITE;
                            byte_ready <= 1'b0;
                            we         <= 1'b1;
                            waddr      <= WIDTH'(addr);
                            wdata      <= WIDTH'(merge_last_lane(asm_word, byte_in));
                        end
                    end
                end

                // The address only advances when another word follows, so it
                // never moves past N-1.
                S_WRITE: begin
                    idx <= '0;
                    if (addr_inc == count) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        addr       <= addr_inc;
                        state      <= S_DATA;
                        byte_ready <= 1'b1;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 1024;

    typedef logic [7:0]  bq_t[$];
    typedef logic [63:0] wq_t[$];

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             we;
    logic [WIDTH-1:0] waddr;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             error;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc      = 0;
    int  last_we  = -100;
    wq_t wr_q;

    imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: records every strobe and checks its spacing and context.
    always @(negedge clk) begin
        cyc++;
        if (we) begin
            wr_q.push_back({waddr, wdata});
            check_val("we_spacing", 64'(cyc - last_we >= 5), 64'd1);
            check_val("we_while_busy", 64'(busy), 64'd1);
            last_we = cyc;
        end
    end

    // Reference model: header gives N; N==0 finishes, N>DEPTH errors,
    // otherwise word i is the little-endian 4-byte group i at address i.
    function automatic void model(input bq_t s, output wq_t w, output bit exp_done, output bit exp_err);
        int n;
        logic [31:0] word;
        w = {};
        n = int'(s[0]) + 256 * int'(s[1]);
        exp_err  = (n > DEPTH);
        exp_done = !exp_err;
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                word = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
                w.push_back({32'(i), word});
            end
        end
    endfunction

    function automatic bq_t make_stream(input int n);
        bq_t s;
        s = {};
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        if (n <= DEPTH) begin
            for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
        end
        return s;
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit pulse_start, output bit ok);
        int guard;
        bit xfer;
        guard = 0;
        xfer  = 1'b0;
        ok    = 1'b1;
        start = pulse_start;
        while (!xfer) begin
            byte_in    = b;
            byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            xfer = byte_valid && byte_ready;
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
            if (!xfer && guard > 100) begin
                ok = 1'b0;
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int g;
        g = 0;
        while (busy && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check_val({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic run_load(input bq_t s, input bit gaps, input int start_at, input string tag);
        wq_t exp_w;
        bit  ed, ee, ok;
        model(s, exp_w, ed, ee);
        wr_q = {};
        do_start();
        for (int i = 0; i < s.size(); i++) begin
            send_byte(s[i], gaps, (i == start_at), ok);
            if (!ok) begin
                check_val({tag, "_stall"}, 64'd0, 64'd1);
                break;
            end
        end
        wait_idle(tag);
        check_val({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
            check_val({tag, "_wr"}, wr_q[i], exp_w[i]);
        check_val({tag, "_done"}, 64'(done), 64'(ed));
        check_val({tag, "_err"}, 64'(error), 64'(ee));
    endtask

    initial begin
        bq_t s;
        wq_t ref_w, exp_w;
        bit  ed, ee, ok;
        int  n;

        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready", 64'(byte_ready), 64'd0);
        check_val("rst_busy",  64'(busy),       64'd0);
        check_val("rst_done",  64'(done),       64'd0);
        check_val("rst_error", 64'(error),      64'd0);
        check_val("rst_waddr", 64'(waddr),      64'd0);
        check_val("rst_wdata", 64'(wdata),      64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Two-word reference load.
        s = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(s, 1'b0, -1, "n2");
        check_val("n2_w0", wr_q.size() > 0 ? wr_q[0] : 64'hdead, {32'd0, 32'h0000_0013});
        check_val("n2_w1", wr_q.size() > 1 ? wr_q[1] : 64'hdead, {32'd1, 32'h0010_0093});

        // Empty header: done on the cycle after the second header byte.
        wr_q = {};
        do_start();
        send_byte(8'h00, 1'b0, 1'b0, ok);
        send_byte(8'h00, 1'b0, 1'b0, ok);
        check_val("n0_done", 64'(done), 64'd1);
        check_val("n0_busy", 64'(busy), 64'd0);
        check_val("n0_nwr",  64'(wr_q.size()), 64'd0);

        // Oversized count, then restart clears error.
        run_load({8'h01, 8'h04}, 1'b0, -1, "big");
        do_start();
        check_val("restart_err",   64'(error),      64'd0);
        check_val("restart_busy",  64'(busy),       64'd1);
        check_val("restart_ready", 64'(byte_ready), 64'd1);
        send_byte(8'h00, 1'b0, 1'b0, ok);
        send_byte(8'h00, 1'b0, 1'b0, ok);
        check_val("restart_done", 64'(done), 64'd1);

        // Gap-free versus randomly stalled run of the same 4-word stream.
        s = make_stream(4);
        run_load(s, 1'b0, -1, "nogap");
        ref_w = wr_q;
        run_load(s, 1'b1, -1, "gap");
        check_val("gap_count", 64'(wr_q.size()), 64'(ref_w.size()));
        for (int i = 0; i < ref_w.size() && i < wr_q.size(); i++)
            check_val("gap_same", wr_q[i], ref_w[i]);

        // Start pulsed while in the payload.
        run_load(make_stream(3), 1'b0, 5, "start_in_data");
        run_load(make_stream(2), 1'b1, 7, "start_in_data_gap");

        // Reset after the sixth payload byte of a 3-word load.
        s = make_stream(3);
        model(s, exp_w, ed, ee);
        wr_q = {};
        do_start();
        for (int i = 0; i < 8; i++) send_byte(s[i], 1'b0, 1'b0, ok);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("abort_ready", 64'(byte_ready), 64'd0);
        check_val("abort_we",    64'(we),         64'd0);
        check_val("abort_busy",  64'(busy),       64'd0);
        check_val("abort_done",  64'(done),       64'd0);
        check_val("abort_error", 64'(error),      64'd0);
        check_val("abort_waddr", 64'(waddr),      64'd0);
        check_val("abort_wdata", 64'(wdata),      64'd0);
        byte_valid = 1'b1;
        for (int i = 8; i < s.size(); i++) begin
            byte_in = s[i];
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        check_val("abort_nwr", 64'(wr_q.size()), 64'd1);
        check_val("abort_w0", wr_q.size() > 0 ? wr_q[0] : 64'hdead, exp_w[0]);
        run_load(make_stream(1), 1'b0, -1, "after_abort");

        // Randomized loads with gaps, empty/oversized headers and stray starts.
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 7))
                0:       n = 0;
                1:       n = DEPTH + 1 + $urandom_range(0, 3000);
                default: n = $urandom_range(1, 6);
            endcase
            s = make_stream(n);
            run_load(s, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 1) ? int'($urandom_range(0, s.size() - 1)) : -1,
                     "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
